mii_groove_deframer: RTL
========================

// Module: mii_groove_deframer
// PURPOSE
// - Ingress stage in front of the Ethernet echo path. Takes raw MII RX nibbles and strips the preamble/SFD.
// - Packs nibbles into bytes (low nibble first) and buffers them in a FIFO.
// - Presents the bytes on a valid/ready stream with per-frame last/error tags, plus frame statistics.
// PARAMETERS
// - FIFO_DEPTH   16   stream FIFO entries; power of 2, >=4
// - CNT_W        16   width of the saturating statistics counters
// PORTS
// - clkDiscoMaster    in   1      system clock; all logic on rising edge
// - partyReset        in   1      async active-high reset
// - netRxNibbleStrobe in   1      qualifier: RX inputs are sampled only in cycles where this is 1
// - netRxGrooveValid  in   1      MII RX_DV
// - netRxOops         in   1      MII RX_ER
// - netRxData         in   4      MII RXD
// - grooveByte        out  8      stream data
// - grooveValid       out  1      stream valid (FIFO non-empty)
// - grooveReady       in   1      consumer ready
// - grooveLast        out  1      final byte of frame
// - grooveErr         out  1      frame bad; meaningful only when grooveLast=1
// - fifoLevel         out  $clog2(FIFO_DEPTH)+1  current entry count
// - frameCount        out  CNT_W  good frames delivered (saturating)
// - errCount          out  CNT_W  errored frames delivered (saturating)
// - dropCount         out  CNT_W  frames discarded with no entry pushed (saturating)
// BEHAVIOUR
// - Reset values:
//   - grooveByte=0, grooveValid/Last/Err=0, fifoLevel=0, all counters=0.
//   - FIFO emptied, hold register empty, state=IDLE.
// - Sampling: a "strobe" is a cycle with netRxNibbleStrobe=1. No state changes on non-strobe cycles, except FLUSH and FIFO pop.
// - FSM states: IDLE, PREAMBLE, PAYLOAD, DROP, FLUSH.
//   - IDLE: strobe && valid -> PREAMBLE, with the first nibble checked as in PREAMBLE.
//   - PREAMBLE (strobe && valid):
//     - nibble 0x5: stay.
//     - nibble 0xD: -> PAYLOAD, with nibble phase=low and sticky err=0.
//     - any other nibble, or netRxOops=1: -> DROP, dropCount++.
//   - PREAMBLE, strobe && !valid: -> IDLE, dropCount++.
//   - PAYLOAD, strobe && valid:
//     - low phase: latch the nibble into bits [3:0].
//     - high phase: form byte {nibble, low}.
//     - netRxOops on any nibble sets sticky err.
//   - PAYLOAD, strobe && !valid (end of frame): an odd nibble count sets err; the partial nibble is discarded. Then:
//     - hold register empty: no push, dropCount++, -> IDLE.
//     - otherwise: -> FLUSH.
//   - DROP: ignore nibbles until strobe && !valid, then -> IDLE.
//   - FLUSH:
//     - Pushes the held byte with last=1, err=sticky in the first cycle the FIFO is not full, then -> IDLE.
//     - If strobe && valid occurs while in FLUSH, that frame is discarded: dropCount++ once, and the FSM goes to DROP after the push.
// - Hold-back register (needed so last can be tagged):
//   - Each completed byte pushes the previously held byte (last=0) and becomes the new held byte.
//   - The first byte of a frame only fills the hold register.
// - Overflow:
//   - A last=0 push while the FIFO is full discards that byte and sets sticky err.
//   - The frame still terminates through FLUSH with last=1, err=1.
// - FIFO:
//   - Entries are {err, last, byte}, first-word fall-through.
//   - Push is allowed only if fifoLevel < FIFO_DEPTH, evaluated before the same-cycle pop. There is no bypass.
//   - Push and pop in the same cycle leave fifoLevel unchanged.
// - Stream:
//   - Transfer when grooveValid && grooveReady.
//   - grooveByte, grooveLast and grooveErr are held stable while grooveValid && !grooveReady.
// - Latency: a byte is pushed on the edge after its next byte's high-nibble strobe (or after the FLUSH push). grooveValid rises the cycle after the push.
// - Counters:
//   - On a last=1 push: err=0 -> frameCount++, err=1 -> errCount++.
//   - All counters saturate at all-ones; there is no wrap.
// - Reset mid-frame:
//   - Async clear to reset values; FIFO contents are lost.
//   - After release, a frame already in progress enters PREAMBLE. A non-0x5/0xD nibble sends it to DROP with dropCount=1.
// TESTING
// - Preamble 15x0x5, 0xD, bytes 0x12 0x34 0xAB; always ready
//   -> stream 12/34/AB; last only on AB; err=0; frameCount=1.
// - Same frame with netRxOops pulsed on the 2nd payload nibble
//   -> three bytes delivered, AB has last=1 err=1; errCount=1, frameCount=0.
// - Frame with first nibble 0x3
//   -> no FIFO entries, dropCount=1, state back to IDLE after valid drops.
//   - SFD followed immediately by !valid -> dropCount=2.
// - FIFO_DEPTH=16, grooveReady=0, 20-byte frame
//   -> 16 entries stored, overflow discards, fifoLevel stays 16 with state FLUSH.
//   - Raising ready then drains 16 entries plus the FLUSH byte with last=1 err=1.
// - Frame of 5 nibbles
//   -> 2 bytes, the second with last=1 err=1 (odd nibble count).
//   - Then partyReset asserted mid-byte of the next frame -> all outputs 0, fifoLevel=0.

Source files
------------

// File: rtl/mii_groove_deframer_if.sv
// mii_groove_deframer_if
//   Bundles the MII receive inputs, the byte stream and the frame statistics
//   of mii_groove_deframer.
//   master : deframer side (samples RX nibbles and ready, drives the stream and stats)
//   slave  : environment side (drives RX nibbles and ready, observes stream and stats)
//   Signals:
//     netRxNibbleStrobe, netRxGrooveValid, netRxOops, netRxData[3:0]  - MII RX
//     grooveByte[7:0], grooveValid, grooveReady, grooveLast, grooveErr - stream
//     fifoLevel, frameCount, errCount, dropCount                       - status
interface mii_groove_deframer_if #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             netRxNibbleStrobe;
    logic             netRxGrooveValid;
    logic             netRxOops;
    logic [3:0]       netRxData;
    logic [7:0]       grooveByte;
    logic             grooveValid;
    logic             grooveReady;
    logic             grooveLast;
    logic             grooveErr;
    logic [LVL_W-1:0] fifoLevel;
    logic [CNT_W-1:0] frameCount;
    logic [CNT_W-1:0] errCount;
    logic [CNT_W-1:0] dropCount;

    modport master (
        input  netRxNibbleStrobe, netRxGrooveValid, netRxOops, netRxData, grooveReady,
        output grooveByte, grooveValid, grooveLast, grooveErr,
        output fifoLevel, frameCount, errCount, dropCount
    );

    modport slave (
        output netRxNibbleStrobe, netRxGrooveValid, netRxOops, netRxData, grooveReady,
        input  grooveByte, grooveValid, grooveLast, grooveErr,
        input  fifoLevel, frameCount, errCount, dropCount
    );
endinterface

// File: rtl/mii_groove_deframer.sv
// mii_groove_deframer
//   Strips preamble/SFD from MII RX nibbles, packs payload nibbles into bytes
//   (low nibble first), and queues them as {err,last,byte} in a first-word
//   fall-through FIFO presented as a valid/ready stream. Keeps saturating
//   counts of good, errored and dropped frames.
//   Ports:
//     clkDiscoMaster - clock, rising edge
//     partyReset     - asynchronous active-high reset
//     bus            - mii_groove_deframer_if.master (RX nibbles, stream, stats)
module mii_groove_deframer #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                   clkDiscoMaster,
    input  logic                   partyReset,
    mii_groove_deframer_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, DROP, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [3:0]       low_q, low_d;
    logic             high_q, high_d;     // next nibble is the high half
    logic             err_q, err_d;       // sticky frame error
    logic [7:0]       hold_q, hold_d;     // held-back byte, so last can be tagged
    logic             held_q, held_d;
    logic             pend_q, pend_d;     // frame seen during FLUSH, go to DROP after push
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [CNT_W-1:0] frame_cnt_q, err_cnt_q, drop_cnt_q;
    logic [9:0]       mem [FIFO_DEPTH];

    logic       push, pop, full, seen;
    logic [9:0] push_word, head;
    logic       frame_inc, err_inc, drop_inc;
    logic       strobe, dv, er;
    logic [3:0] nib;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign strobe = bus.netRxNibbleStrobe;
    assign dv     = bus.netRxGrooveValid;
    assign er     = bus.netRxOops;
    assign nib    = bus.netRxData;
    // Fullness is judged before any same-cycle pop: no bypass path.
    assign full   = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop    = (level_q != '0) && bus.grooveReady;
    assign head   = mem[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        high_d    = high_q;
        err_d     = err_q;
        hold_d    = hold_q;
        held_d    = held_q;
        pend_d    = pend_q;
        push      = 1'b0;
        push_word = '0;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        drop_inc  = 1'b0;
        seen      = pend_q;
        case (state_q)
            IDLE, PREAMBLE: begin
                if (strobe && dv) begin
                    if (er || (nib != 4'h5 && nib != 4'hD)) begin
                        state_d  = DROP;
                        drop_inc = 1'b1;
                    end else if (nib == 4'hD) begin
                        state_d = PAYLOAD;
                        high_d  = 1'b0;
                        err_d   = 1'b0;
                        held_d  = 1'b0;
                    end else begin
                        state_d = PREAMBLE;
                    end
                end else if (strobe && state_q == PREAMBLE) begin
                    state_d  = IDLE;
                    drop_inc = 1'b1;
                end
            end
            PAYLOAD: begin
                if (strobe && dv) begin
                    if (er) err_d = 1'b1;
                    if (!high_q) begin
                        low_d  = nib;
                        high_d = 1'b1;
                    end else begin
                        high_d = 1'b0;
                        hold_d = {nib, low_q};
                        held_d = 1'b1;
                        if (held_q) begin
                            if (full) begin
                                err_d = 1'b1;
                            end else begin
                                push      = 1'b1;
                                push_word = {2'b00, hold_q};
                            end
                        end
                    end
                end else if (strobe) begin
                    if (high_q) err_d = 1'b1;
                    if (held_q) begin
                        state_d = FLUSH;
                    end else begin
                        state_d  = IDLE;
                        drop_inc = 1'b1;
                    end
                end
            end
            DROP: begin
                if (strobe && !dv) state_d = IDLE;
            end
            FLUSH: begin
                if (strobe && dv && !pend_q) begin
                    drop_inc = 1'b1;
                    pend_d   = 1'b1;
                    seen     = 1'b1;
                end
                if (!full) begin
                    push      = 1'b1;
                    push_word = {err_q, 1'b1, hold_q};
                    held_d    = 1'b0;
                    pend_d    = 1'b0;
                    err_inc   = err_q;
                    frame_inc = !err_q;
                    state_d   = seen ? DROP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkDiscoMaster or posedge partyReset) begin
        if (partyReset) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge clkDiscoMaster or posedge partyReset) begin
        if (partyReset) begin
            low_q       <= '0;
            high_q      <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= '0;
            held_q      <= 1'b0;
            pend_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            low_q  <= low_d;
            high_q <= high_d;
            err_q  <= err_d;
            hold_q <= hold_d;
            held_q <= held_d;
            pend_q <= pend_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      level_q <= level_q + LVL_W'(1);
            else if (!push && pop) level_q <= level_q - LVL_W'(1);
            if (frame_inc) frame_cnt_q <= sat_inc(frame_cnt_q);
            if (err_inc)   err_cnt_q   <= sat_inc(err_cnt_q);
            if (drop_inc)  drop_cnt_q  <= sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clkDiscoMaster) begin
        if (push) mem[wr_ptr_q] <= push_word;
    end

    // Stream fields are forced to zero while empty so reset/idle outputs read 0.
    assign bus.grooveValid = (level_q != '0);
    assign bus.grooveByte  = bus.grooveValid ? head[7:0] : '0;
    assign bus.grooveLast  = bus.grooveValid ? head[8]   : 1'b0;
    assign bus.grooveErr   = bus.grooveValid ? head[9]   : 1'b0;
    assign bus.fifoLevel   = level_q;
    assign bus.frameCount  = frame_cnt_q;
    assign bus.errCount    = err_cnt_q;
    assign bus.dropCount   = drop_cnt_q;
endmodule
